// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction memory port, redirect request and the
// valid/ready instruction stream toward decode.
interface ifetch_queue_if;
  // Handshake: an entry transfers on a rising clk edge when instr_valid and
  // instr_ready are both high; instr_valid never depends on instr_ready, and
  // instr/instr_pc/instr_pcplus4 are stable while instr_valid is held.
  logic [5:0]  imem_a;
  logic [31:0] imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  modport master (
    output imem_a, instr_valid, instr, instr_pc, instr_pcplus4,
    input  imem_rd, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_a, instr_valid, instr, instr_pc, instr_pcplus4,
    output imem_rd, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: sequential fetch PC feeding a small circular queue
// of {pc, instr} entries, flushed and refetched on redirect.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  ifetch_queue_if.master           bus,
  output logic [$clog2(QDEPTH):0]  count_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q  [QDEPTH];
  logic [31:0]   ins_mem_q [QDEPTH];
  logic          valid, deq, enq;

  assign valid = (count_q != '0);
  assign deq   = valid & bus.instr_ready;
  // A full queue may still accept when its head leaves in the same cycle.
  assign enq   = !bus.redirect & ((count_q < CW'(QDEPTH)) | deq);

  always_comb begin
    fpc_d   = fpc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset) begin
      fpc_d   = RESET_PC & 32'hFFFF_FFFC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (bus.redirect) begin
      fpc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = head_q + PW'(1);
      if (enq) begin
        tail_d = tail_q + PW'(1);
        fpc_d  = fpc_q + 32'd4;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fpc_q   <= fpc_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      pc_mem_q[tail_q]  <= fpc_q;
      ins_mem_q[tail_q] <= bus.imem_rd;
    end
  end

  assign bus.imem_a        = fpc_q[7:2];
  assign bus.instr_valid   = valid;
  assign bus.instr         = valid ? ins_mem_q[head_q] : 32'h0;
  assign bus.instr_pc      = valid ? pc_mem_q[head_q] : 32'h0;
  assign bus.instr_pcplus4 = valid ? (pc_mem_q[head_q] + 32'd4) : 32'h0;
  assign count_o           = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (RESET_PC = 0, QDEPTH = 2): vector table
// for streaming, stall, redirect, wrap and reset, plus an ordering run.
module tb_ifetch_queue;
  logic       clk;
  logic       reset;
  logic [1:0] count;
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [31:0] exp_q[$];

  ifetch_queue_if bus();

  ifetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .count_o (count)
  );

  // Instruction memory model: word k holds 32'h2000_0000 + k.
  assign bus.imem_rd = 32'h2000_0000 + {26'b0, bus.imem_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [5:0]  a;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[27];

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    word_at = 32'h2000_0000 + {26'b0, pc[7:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [5:0] a, input logic [1:0] cnt);
    chk({tag, " valid"},  {31'b0, bus.instr_valid}, {31'b0, v});
    chk({tag, " pc"},     bus.instr_pc,      v ? pc : 32'h0);
    chk({tag, " instr"},  bus.instr,         v ? word_at(pc) : 32'h0);
    chk({tag, " pcp4"},   bus.instr_pcplus4, v ? pc + 32'd4 : 32'h0);
    chk({tag, " imem_a"}, {26'b0, bus.imem_a}, {26'b0, a});
    chk({tag, " count"},  {30'b0, count},    {30'b0, cnt});
  endtask

  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
    reset           = rst;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.instr_ready = rdy;
  endtask

  initial begin
    //            rst redir rpc           rdy | v  pc            a      cnt
    // streaming from reset
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        6'd0,  2'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        6'd1,  2'd1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        6'd2,  2'd1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        6'd3,  2'd1};
    // reset, then backpressure for 5 cycles
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        6'd4,  2'd1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0,  2'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        6'd1,  2'd1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        6'd2,  2'd2};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        6'd2,  2'd2};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        6'd2,  2'd2};
    // full with simultaneous deq for 3 cycles
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        6'd2,  2'd2};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        6'd3,  2'd2};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        6'd4,  2'd2};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        6'd5,  2'd2};
    // redirect to 0x43 while full
    tbl[14] = '{1'b0, 1'b1, 32'h43,       1'b0, 1'b1, 32'hC,        6'd5,  2'd2};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd16, 2'd0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       6'd17, 2'd1};
    tbl[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       6'd18, 2'd1};
    // redirect near top of address space; dequeued head is discarded
    tbl[18] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h48,      6'd19, 2'd1};
    tbl[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        6'd62, 2'd0};
    tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFF8, 6'd63, 2'd1};
    tbl[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 6'd0,  2'd1};
    tbl[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        6'd1,  2'd1};
    // fill to 2, then reset together with redirect
    tbl[23] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        6'd2,  2'd1};
    tbl[24] = '{1'b1, 1'b1, 32'h80,       1'b0, 1'b1, 32'h4,        6'd3,  2'd2};
    tbl[25] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0,  2'd0};
    tbl[26] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        6'd1,  2'd1};

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_out("reset", 1'b0, 32'h0, 6'd0, 2'd0);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      #1;
      check_out($sformatf("r%0d", i), tbl[i].v, tbl[i].pc, tbl[i].a, tbl[i].cnt);
    end

    // Ordering run under an irregular ready pattern: no gaps, no repeats.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(k * 4));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, (c % 3) != 1);
      #1;
      if (bus.instr_valid && bus.instr_ready && exp_q.size() > 0) begin
        chk($sformatf("order c%0d pc", c), bus.instr_pc, exp_q[0]);
        chk($sformatf("order c%0d instr", c), bus.instr, word_at(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    chk("order drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL provide parameter QDEPTH, default 2: instruction queue entries; legal values 2, 4, 8.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port imem_a  output  6: instruction memory word index, equal to fpc[7:2].
REQ-006 SHALL have port imem_rd  input  32: instruction word returned combinationally for imem_a.
REQ-007 SHALL have port redirect  input  1: branch/jump taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  32: new fetch byte address.
REQ-009 SHALL have port instr_ready  input  1: decode stage accepts the head entry this cycle.
REQ-010 SHALL have port instr_valid  output  1: the head entry is valid.
REQ-011 SHALL have port instr  output  32: head instruction word.
REQ-012 SHALL have port instr_pc  output  32: byte address of the head instruction.
REQ-013 SHALL have port instr_pcplus4  output  32: instr_pc + 4, modulo 2^32.

Function
REQ-014 SHALL hold a 32-bit fetch PC register fpc with fpc[1:0] always 2'b00.
REQ-015 SHALL hold a circular queue of QDEPTH entries {pc, instr}, with head pointer, tail pointer, and a count of 0..QDEPTH.
REQ-016 SHALL define deq = instr_valid & instr_ready; head advances and count decrements on deq.
REQ-017 SHALL define enq = !redirect & (count < QDEPTH | deq); on enq, {fpc, imem_rd} is written at tail, tail advances, and fpc <= fpc + 4.
REQ-018 SHALL allow simultaneous enq and deq when full; count is then unchanged and no entry is lost or duplicated.
REQ-019 SHALL hold fpc and the queue unchanged when full and not dequeuing (stall).
REQ-020 SHALL, on redirect, set count, head and tail to 0 and set fpc <= {redirect_pc[31:2], 2'b00}; no enq occurs that cycle.
REQ-021 SHALL discard any entry dequeued in a redirect cycle; decode owns squashing the consumer side.
REQ-022 SHALL make an enqueued entry visible at the head in the cycle after enq (one-cycle fetch latency); the first post-redirect instruction appears two cycles after the redirect cycle.
REQ-023 SHALL drive instr_valid = (count != 0), combinationally from registered state only.
REQ-024 SHALL drive instr, instr_pc and instr_pcplus4 to 32'h0 when instr_valid = 0 (instr 0 is the MIPS nop).
REQ-025 SHALL wrap fpc from 32'hFFFF_FFFC to 32'h0000_0000; imem_a wraps from 63 to 0 every 256 bytes.
REQ-026 SHALL wrap head and tail pointers modulo QDEPTH.
REQ-027 SHALL not combinationally depend on instr_ready or redirect for instr_valid, instr, instr_pc, or imem_a.

Reset
REQ-028 SHALL, while reset = 1, set fpc = RESET_PC, count = 0, head = tail = 0; reset overrides redirect and enq.
REQ-029 SHALL produce, in the first cycle after reset: instr_valid = 0, instr = 0, instr_pc = 0, instr_pcplus4 = 0, and imem_a = RESET_PC[7:2].
REQ-030 SHALL behave identically for reset asserted mid-stream; queue contents are discarded.

Verification
REQ-031 SHALL cover streaming: with RESET_PC = 0, instr_ready held at 1, and imem holding word k = 32'h2000_0000 + k -> instr_valid rises in cycle 1 after reset, then instr_pc = 0, 4, 8, ... each cycle with matching instr.
REQ-032 SHALL cover backpressure: instr_ready = 0 for 5 cycles -> count saturates at QDEPTH, fpc holds at 4*QDEPTH, and the head stays at pc 0; after release, the order is 0, 4, 8 with no gaps.
REQ-033 SHALL cover redirect: redirect = 1 with redirect_pc = 32'h0000_0043 while the queue is full -> instr_valid = 0 next cycle; the next cycle gives instr_pc = 32'h40 and instr = word 16.
REQ-034 SHALL cover full plus simultaneous deq: with count = QDEPTH and instr_ready = 1 for 3 cycles -> count stays QDEPTH and the output pcs are consecutive.
REQ-035 SHALL cover wrap: redirect to 32'hFFFF_FFF8 -> instr_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_a = 62, 63, 0; instr_pcplus4 for FFFF_FFFC is 0.
REQ-036 SHALL cover reset mid-operation: reset asserted together with redirect while count = 2 -> next cycle instr_valid = 0 and imem_a = RESET_PC[7:2].
